// File: rtl/bp_pkg.sv
// Shared types and counter arithmetic for the gshare branch predictor.
// The helper functions work on the widest supported counter so that every
// instance, whatever its CTR_BITS, uses the same saturation rule.
package bp_pkg;

    // Widest table index and counter the helpers and the update struct carry
    localparam int MAX_INDEX_BITS = 16;
    localparam int MAX_CTR_BITS   = 16;

    // One training request from the branch-resolution side
    typedef struct packed {
        logic [MAX_INDEX_BITS-1:0] index;
        logic                      taken;
    } upd_req_t;

    // Reset value: weakly not-taken, i.e. just below the taken threshold
    function automatic logic [MAX_CTR_BITS-1:0] ctr_init(input int ctrBits);
        return MAX_CTR_BITS'((1 << (ctrBits - 1)) - 1);
    endfunction

    // Saturating step: the sum is formed one bit wider than the counter so
    // an overflow past the top or an underflow below zero is visible and
    // can be clamped instead of wrapping
    function automatic logic [MAX_CTR_BITS-1:0] ctr_next(
        input logic [MAX_CTR_BITS-1:0] ctr,
        input logic                    taken,
        input int                      ctrBits
    );
        logic [MAX_CTR_BITS:0] wide;
        logic [MAX_CTR_BITS:0] maxVal;
        maxVal = (MAX_CTR_BITS + 1)'((1 << ctrBits) - 1);
        if (taken) begin
            wide = {1'b0, ctr} + 1'b1;
            if (wide > maxVal) begin
                wide = maxVal;
            end
        end else begin
            wide = {1'b0, ctr} - 1'b1;
            if (wide[MAX_CTR_BITS]) begin
                wide = '0;
            end
        end
        return wide[MAX_CTR_BITS-1:0];
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One saturating direction counter of the prediction table.
// It only moves when its entry is the target of a resolved branch.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    localparam logic [CTR_BITS-1:0] INIT = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q;
    logic [CTR_BITS-1:0] ctr_d;

    // Step towards the resolved outcome when selected, otherwise hold
    always_comb begin
        ctr_d = ctr_q;
        if (en_i) begin
            ctr_d = CTR_BITS'(ctr_next(MAX_CTR_BITS'(ctr_q), taken_i, CTR_BITS));
        end
    end

    // Counter state, returning to weakly not-taken on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q <= INIT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: a table of saturating counters indexed by the
// branch PC hashed with the global outcome history. Lookups are answered one
// cycle later from registered outputs; resolved branches train the table and
// shift the history. With HIST_BITS=0 the hash vanishes and it is bimodal.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter  int PC_BITS    = 32,
    parameter  int INDEX_BITS = 6,
    parameter  int CTR_BITS   = 2,
    parameter  int HIST_BITS  = 4,
    localparam int GHR_W      = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [PC_BITS-1:0]    req_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    output logic [GHR_W-1:0]      ghr
);

    localparam int NUM_ENTRIES = 1 << INDEX_BITS;

    // Configurations the hash or the helper functions cannot support
    if (HIST_BITS > INDEX_BITS || HIST_BITS < 0) begin : g_bad_hist
        $error("gshare_predictor: HIST_BITS must be within 0..INDEX_BITS");
    end
    if (CTR_BITS < 1 || CTR_BITS > MAX_CTR_BITS) begin : g_bad_ctr
        $error("gshare_predictor: CTR_BITS out of supported range");
    end
    if (INDEX_BITS < 1 || INDEX_BITS > MAX_INDEX_BITS) begin : g_bad_index
        $error("gshare_predictor: INDEX_BITS out of supported range");
    end
    if (PC_BITS < INDEX_BITS + 2) begin : g_bad_pc
        $error("gshare_predictor: PC_BITS too narrow for the table index");
    end

    upd_req_t              updReq;
    logic [INDEX_BITS-1:0] updIdx;
    logic [INDEX_BITS-1:0] pcIndex;
    logic [INDEX_BITS-1:0] ghrExt;
    logic [INDEX_BITS-1:0] lookupIdx;
    logic [CTR_BITS-1:0]   ctrVal [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] ctrEn;
    logic [CTR_BITS-1:0]   lookupCtr;

    logic                  predValid_q;
    logic                  predValid_d;
    logic                  predTaken_q;
    logic                  predTaken_d;
    logic [INDEX_BITS-1:0] predIndex_q;
    logic [INDEX_BITS-1:0] predIndex_d;

    // The caller's index is trusted as given; it is never rebuilt from ghr
    assign updReq.index = MAX_INDEX_BITS'(upd_index);
    assign updReq.taken = upd_taken;
    assign updIdx       = updReq.index[INDEX_BITS-1:0];

    // Low PC bits are the byte offset and the high bits fall outside the table
    logic unusedBits;
    assign unusedBits = ^{req_pc, updReq};

    // Global history shifts in each resolved outcome, oldest bit falls off
    if (HIST_BITS > 0) begin : g_hist
        logic [HIST_BITS-1:0] ghr_q;
        logic [HIST_BITS-1:0] ghr_d;

        // Next history value from the resolving branch, if any
        always_comb begin
            ghr_d = ghr_q;
            if (upd_valid) begin
                ghr_d = HIST_BITS'({ghr_q, updReq.taken});
            end
        end

        // History register, cleared on reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ghr_q <= '0;
            end else begin
                ghr_q <= ghr_d;
            end
        end

        assign ghr    = ghr_q;
        assign ghrExt = INDEX_BITS'(ghr_q);
    end else begin : g_no_hist
        assign ghr    = '0;
        assign ghrExt = '0;
    end

    // Hash uses the registered history, so a same-cycle update cannot leak in
    assign pcIndex   = req_pc[INDEX_BITS+1:2];
    assign lookupIdx = pcIndex ^ ghrExt;

    // One-hot enable of the single counter being trained this cycle
    always_comb begin
        ctrEn = '0;
        if (upd_valid) begin
            ctrEn[updIdx] = 1'b1;
        end
    end

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_ctr
        bp_sat_ctr #(
            .CTR_BITS(CTR_BITS)
        ) u_ctr (
            .clk    (clk),
            .rst    (rst),
            .en_i   (ctrEn[e]),
            .taken_i(updReq.taken),
            .ctr_o  (ctrVal[e])
        );
    end

    // Read the looked-up counter, forwarding the trained value on a collision
    always_comb begin
        lookupCtr = ctrVal[lookupIdx];
        if (upd_valid && (updIdx == lookupIdx)) begin
            lookupCtr = CTR_BITS'(ctr_next(MAX_CTR_BITS'(ctrVal[lookupIdx]),
                                           updReq.taken, CTR_BITS));
        end
    end

    // Capture a new prediction on request; otherwise keep the last one
    always_comb begin
        predValid_d = req_valid;
        predTaken_d = predTaken_q;
        predIndex_d = predIndex_q;
        if (req_valid) begin
            predTaken_d = lookupCtr[CTR_BITS-1];
            predIndex_d = lookupIdx;
        end
    end

    // Output registers; reset also kills any prediction still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            predValid_q <= 1'b0;
            predTaken_q <= 1'b0;
            predIndex_q <= '0;
        end else begin
            predValid_q <= predValid_d;
            predTaken_q <= predTaken_d;
            predIndex_q <= predIndex_d;
        end
    end

    assign pred_valid = predValid_q;
    assign pred_taken = predTaken_q;
    assign pred_index = predIndex_q;

endmodule
